// File: rtl/cpu_program_loader_if.sv
// Program byte stream into the loader and the CPU memory write port out of it.
interface cpu_program_loader_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);
   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_last;
   logic              s_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   modport master (
      output s_valid,
      output s_data,
      output s_last,
      input  s_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );

   modport slave (
      input  s_valid,
      input  s_data,
      input  s_last,
      output s_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );
endinterface

// File: rtl/cpu_program_loader.sv
// Boot stage: streams a program into CPU memory from address 0,
// starts the CPU and times the run until it reports done.
module cpu_program_loader #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 5,
   parameter int CNT_W      = 16,
   parameter int MAX_CYCLES = 60000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   cpu_program_loader_if.slave  bus,
   output logic                 cpu_start,
   input  logic                 cpu_done,
   output logic                 busy,
   output logic                 run_done,
   output logic [1:0]           error,
   output logic [ADDR_W:0]      words_loaded,
   output logic [CNT_W-1:0]     run_cycles
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_RUN,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_CYCLES);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic                r_cpu_start;
   logic                r_busy;
   logic                r_run_done;
   logic [1:0]          r_error;
   logic [ADDR_W:0]     r_words;
   logic [CNT_W-1:0]    r_run_cycles;

   logic                w_ready;
   logic                w_xfer;
   logic [CNT_W-1:0]    w_cnt_nxt;

   assign w_ready   = (r_state == S_LOAD);
   assign w_xfer    = bus.s_valid & w_ready;
   assign w_cnt_nxt = r_run_cycles + CNT_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_addr       <= '0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_cpu_start  <= 1'b0;
         r_busy       <= 1'b0;
         r_run_done   <= 1'b0;
         r_error      <= 2'b00;
         r_words      <= '0;
         r_run_cycles <= '0;
      end else begin
         r_mem_we    <= 1'b0;
         r_cpu_start <= 1'b0;
         unique case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (load) begin
                  r_state      <= S_LOAD;
                  r_addr       <= '0;
                  r_words      <= '0;
                  r_run_cycles <= '0;
                  r_error      <= 2'b00;
                  r_run_done   <= 1'b0;
                  r_busy       <= 1'b1;
               end
            end
            S_LOAD: begin
               if (w_xfer) begin
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= r_addr;
                  r_mem_wdata <= bus.s_data;
                  r_addr      <= r_addr + ADDR_W'(1);
                  r_words     <= r_words + (ADDR_W+1)'(1);
                  if (bus.s_last) begin
                     r_state <= S_START;
                  end else if (r_addr == LAST_ADDR) begin
                     // memory full without an end marker: stop, never wrap
                     r_state <= S_ERROR;
                     r_error <= 2'b01;
                     r_busy  <= 1'b0;
                  end
               end
            end
            S_START: begin
               r_cpu_start  <= 1'b1;
               r_run_cycles <= CNT_W'(1);
               r_state      <= S_RUN;
            end
            S_RUN: begin
               if (cpu_done) begin
                  r_state    <= S_DONE;
                  r_run_done <= 1'b1;
                  r_busy     <= 1'b0;
               end else begin
                  r_run_cycles <= w_cnt_nxt;
                  if (w_cnt_nxt == MAX_CNT) begin
                     r_state <= S_ERROR;
                     r_error <= 2'b10;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.s_ready   = w_ready;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign cpu_start     = r_cpu_start;
   assign busy          = r_busy;
   assign run_done      = r_run_done;
   assign error         = r_error;
   assign words_loaded  = r_words;
   assign run_cycles    = r_run_cycles;
endmodule

// File: tb/tb_cpu_program_loader.sv
// Directed plus randomized checks of the program loader against a
// cycle-level model of load, start latency, run timing and errors.
module tb_cpu_program_loader;
   localparam int DW    = 8;
   localparam int AW    = 5;
   localparam int CW    = 16;
   localparam int MAXC  = 20;
   localparam int DEPTH = 1 << AW;

   logic          clk      = 1'b0;
   logic          rst      = 1'b0;
   logic          load     = 1'b0;
   logic          cpu_done = 1'b0;
   logic          cpu_start;
   logic          busy;
   logic          run_done;
   logic [1:0]    error;
   logic [AW:0]   words_loaded;
   logic [CW-1:0] run_cycles;

   cpu_program_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   cpu_program_loader #(
      .DATA_W(DW),
      .ADDR_W(AW),
      .CNT_W(CW),
      .MAX_CYCLES(MAXC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .load(load),
      .bus(bus),
      .cpu_start(cpu_start),
      .cpu_done(cpu_done),
      .busy(busy),
      .run_done(run_done),
      .error(error),
      .words_loaded(words_loaded),
      .run_cycles(run_cycles)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int wr_addr[$];
   int wr_data[$];
   int wr_cyc[$];
   int st_cyc[$];

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         wr_addr.push_back(int'(bus.mem_addr));
         wr_data.push_back(int'(bus.mem_wdata));
         wr_cyc.push_back(cyc);
      end
      if (cpu_start === 1'b1) st_cyc.push_back(cyc);
   end

   int          n_chk = 0;
   int          n_err = 0;
   logic [DW-1:0] prog [64];
   int          xfer_cyc [64];
   int          acc;
   int          last_t;
   int          c;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_mem_we"}, int'(bus.mem_we), 0);
      chk({pfx, "_mem_addr"}, int'(bus.mem_addr), 0);
      chk({pfx, "_mem_wdata"}, int'(bus.mem_wdata), 0);
      chk({pfx, "_cpu_start"}, int'(cpu_start), 0);
      chk({pfx, "_busy"}, int'(busy), 0);
      chk({pfx, "_run_done"}, int'(run_done), 0);
      chk({pfx, "_error"}, int'(error), 0);
      chk({pfx, "_words"}, int'(words_loaded), 0);
      chk({pfx, "_run_cycles"}, int'(run_cycles), 0);
      chk({pfx, "_s_ready"}, int'(bus.s_ready), 0);
   endtask

   // gap: 0 none, 1 one idle cycle between bytes, 2 random idle cycles
   task automatic load_prog(input int len, input bit last_en,
                            input int gap, input bit dir);
      wr_addr.delete();
      wr_data.delete();
      wr_cyc.delete();
      st_cyc.delete();
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("ready_after_load", int'(bus.s_ready), 1);
      chk("clr_run_done", int'(run_done), 0);
      chk("clr_error", int'(error), 0);
      chk("clr_run_cycles", int'(run_cycles), 0);
      chk("clr_words", int'(words_loaded), 0);
      chk("busy_load", int'(busy), 1);
      acc    = 0;
      last_t = -1;
      for (int i = 0; i < len; i++) begin
         if (gap == 1 && i > 0) begin
            bus.s_valid = 1'b0;
            tick();
         end
         if (gap == 2) begin
            repeat ($urandom_range(0, 2)) begin
               bus.s_valid = 1'b0;
               tick();
            end
         end
         if (bus.s_ready !== 1'b1) break;
         prog[i]     = dir ? DW'((i + 1) * 17) : DW'($urandom);
         bus.s_valid = 1'b1;
         bus.s_data  = prog[i];
         bus.s_last  = last_en && (i == len - 1);
         xfer_cyc[i] = cyc;
         acc++;
         if (bus.s_last) last_t = cyc;
         tick();
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic check_writes(input int n);
      int bad;
      bad = 0;
      chk("accepted", acc, n);
      chk("n_writes", wr_addr.size(), n);
      for (int i = 0; i < n && i < wr_addr.size(); i++) begin
         if (wr_addr[i] != i || wr_data[i] != int'(prog[i]) ||
             wr_cyc[i] != xfer_cyc[i] + 1)
            bad++;
      end
      chk("write_seq", bad, 0);
      chk("words_loaded", int'(words_loaded), n);
   endtask

   // CPU reports done while the run has lasted k cycles (START included)
   task automatic run_prog(input int k);
      bit to;
      c = last_t + 2;
      while (cyc < c + k - 1) begin
         load = (cyc == c);
         tick();
      end
      load     = 1'b0;
      cpu_done = 1'b1;
      tick();
      cpu_done = 1'b0;
      tick();
      tick();
      to = (k >= MAXC);
      chk("cpu_start_once", st_cyc.size(), 1);
      if (st_cyc.size() > 0) chk("cpu_start_cycle", st_cyc[0], c);
      chk("run_done", int'(run_done), to ? 0 : 1);
      chk("run_error", int'(error), to ? 2 : 0);
      chk("run_cycles", int'(run_cycles), to ? MAXC : k);
      chk("busy_end", int'(busy), 0);
      chk("mem_we_end", int'(bus.mem_we), 0);
   endtask

   task automatic overflow(input int len, input int gap);
      load_prog(len, 1'b0, gap, 1'b0);
      tick();
      tick();
      check_writes(DEPTH);
      chk("ovf_error", int'(error), 1);
      chk("ovf_ready", int'(bus.s_ready), 0);
      chk("ovf_busy", int'(busy), 0);
      chk("ovf_no_start", st_cyc.size(), 0);
      chk("ovf_run_done", int'(run_done), 0);
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      repeat (3) tick();
      chk_zero("rst0");
      rst = 1'b1;
      tick();

      // 3-byte program, then reset in the middle of the run
      load_prog(3, 1'b1, 0, 1'b1);
      c = last_t + 2;
      while (cyc < c + 3) tick();
      check_writes(3);
      chk("mid_run_busy", int'(busy), 1);
      chk("mid_run_start", st_cyc.size() > 0 ? st_cyc[0] : -1, c);
      rst = 1'b0;
      #1;
      chk_zero("rst_mid");
      tick();
      rst = 1'b1;
      tick();

      load_prog(3, 1'b1, 0, 1'b1);
      run_prog(10);
      check_writes(3);

      load_prog(4, 1'b1, 1, 1'b0);
      run_prog(5);
      check_writes(4);

      overflow(DEPTH + 1, 0);

      load_prog(DEPTH, 1'b1, 0, 1'b0);
      run_prog(1);
      check_writes(DEPTH);

      load_prog(2, 1'b1, 0, 1'b0);
      run_prog(MAXC - 1);
      check_writes(2);

      load_prog(2, 1'b1, 0, 1'b0);
      run_prog(MAXC + 3);
      check_writes(2);

      repeat (12) begin
         int len;
         len = $urandom_range(1, DEPTH + 4);
         if (len > DEPTH) begin
            overflow(len, 2);
         end else begin
            load_prog(len, 1'b1, 2, 1'b0);
            run_prog($urandom_range(1, MAXC + 4));
            check_writes(len);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
